// File: rtl/crc7_pkg.sv
// rtl/crc7_pkg.sv - shared CRC-7 constants and checker FSM state encoding
package crc7_pkg;

  localparam int          CRC7_WIDTH = 7;
  localparam logic [6:0]  CRC7_POLY  = 7'h09;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } crc7_state_t;

endpackage

// File: rtl/crc_7_check_if.sv
// rtl/crc_7_check_if.sv - request/result bundle between link receiver and CRC-7 checker
interface crc_7_check_if
  import crc7_pkg::*;
#(
  parameter int DATAWIDTH = 32
);

  logic                  start;
  logic [DATAWIDTH-1:0]  data_in;
  logic [7:0]            crc_in;
  logic                  busy;
  logic                  done;
  logic                  crc_ok;
  logic [CRC7_WIDTH-1:0] crc_calc;

  modport master (
    output start, data_in, crc_in,
    input  busy, done, crc_ok, crc_calc
  );

  modport slave (
    input  start, data_in, crc_in,
    output busy, done, crc_ok, crc_calc
  );

endinterface

// File: rtl/crc7_bit_step.sv
// rtl/crc7_bit_step.sv - one MSB-first LFSR step of the CRC-7 remainder
module crc7_bit_step
  import crc7_pkg::*;
#(
  parameter logic [CRC7_WIDTH-1:0] POLY = CRC7_POLY
) (
  input  logic [CRC7_WIDTH-1:0] i_r,
  input  logic                  i_bit,
  output logic [CRC7_WIDTH-1:0] o_r_next
);

  logic w_fb;

  // Feedback is the incoming bit against the remainder MSB; x^7 is implicit.
  always_comb begin
    w_fb     = i_bit ^ i_r[CRC7_WIDTH-1];
    o_r_next = {i_r[CRC7_WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
  end

endmodule

// File: rtl/crc_7_check.sv
// rtl/crc_7_check.sv - bit-serial CRC-7 recompute and compare for a received word
module crc_7_check
  import crc7_pkg::*;
#(
  parameter int                    DATAWIDTH = 32,
  parameter logic [CRC7_WIDTH-1:0] POLY      = CRC7_POLY
) (
  input  logic          clk,
  input  logic          rst,
  crc_7_check_if.slave  bus
);

  // Wide enough to hold DATAWIDTH itself, so the count never wraps mid-word.
  localparam int CNT_W = $clog2(DATAWIDTH + 1);

  crc7_state_t           r_state;
  crc7_state_t           w_state_next;
  logic                  w_accept;
  logic                  w_last_bit;

  logic [DATAWIDTH-1:0]  r_shift;
  logic [CRC7_WIDTH-1:0] r_crc;
  logic [CRC7_WIDTH-1:0] r_crc_rx;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_crc_ok;
  logic [CRC7_WIDTH-1:0] r_crc_calc;
  logic [CRC7_WIDTH-1:0] w_crc_next;

  crc7_bit_step #(
    .POLY (POLY)
  ) u_step (
    .i_r      (r_crc),
    .i_bit    (r_shift[DATAWIDTH-1]),
    .o_r_next (w_crc_next)
  );

  assign w_last_bit = (r_cnt == CNT_W'(DATAWIDTH - 1));

  // Next-state logic: accept only from IDLE, one bit per SHIFT cycle, single CHECK cycle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_bit) begin
          w_state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: latch the word, walk it MSB first, then publish the comparison result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift    <= '0;
      r_crc      <= '0;
      r_crc_rx   <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crc_ok   <= 1'b0;
      r_crc_calc <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift  <= bus.data_in;
            r_crc_rx <= bus.crc_in[CRC7_WIDTH-1:0];
            r_crc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_crc   <= w_crc_next;
          r_shift <= {r_shift[DATAWIDTH-2:0], 1'b0};
          r_cnt   <= r_cnt + 1'b1;
        end
        ST_CHECK: begin
          r_crc_calc <= r_crc;
          r_crc_ok   <= (r_crc == r_crc_rx);
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.crc_ok   = r_crc_ok;
  assign bus.crc_calc = r_crc_calc;

endmodule

// File: tb/tb_crc_7_check.sv
// tb/tb_crc_7_check.sv - scoreboard bench for crc_7_check
module tb_crc_7_check;

  localparam int DW  = 32;
  localparam int LAT = DW + 1;

  typedef struct {
    logic [6:0] calc;
    logic       ok;
    int         done_edge;
  } exp_t;

  logic clk;
  logic rst;
  int   edge_cnt;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  crc_7_check_if #(.DATAWIDTH(DW)) bus ();

  crc_7_check #(
    .DATAWIDTH (DW),
    .POLY      (7'h09)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // Remainder of (d * x^7) mod (x^7 + x^3 + 1) by polynomial long division.
  function automatic logic [6:0] crc_model(input logic [31:0] d);
    logic [38:0] v;
    v = {d, 7'b0};
    for (int i = 38; i >= 7; i--) begin
      if (v[i]) v = v ^ (39'h89 << (i - 7));
    end
    return v[6:0];
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Monitor: every done pops one expectation and checks value and arrival edge.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("crc_calc", 32'(bus.crc_calc), 32'(e.calc));
        check("crc_ok", 32'(bus.crc_ok), 32'(e.ok));
        check("done_edge", 32'(edge_cnt), 32'(e.done_edge));
      end
    end
  end

  function automatic void push_exp(input logic [6:0] calc, input logic ok, input int accept_edge);
    exp_t e;
    e.calc      = calc;
    e.ok        = ok;
    e.done_edge = accept_edge + LAT;
    sb.push_back(e);
  endfunction

  // Drive one start pulse; returns with edge_cnt equal to the accepting edge.
  task automatic issue(input logic [31:0] d, input logic [7:0] c, input bit with_exp,
                       input logic [6:0] calc, input logic ok);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.crc_in  = c;
    if (with_exp) push_exp(calc, ok, edge_cnt + 1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_crc_ok"}, 32'(bus.crc_ok), 32'd0);
    check({tag, "_crc_calc"}, 32'(bus.crc_calc), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  c;
    logic [6:0]  m;
    int          k;
    int          e1;

    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b0;
    bus.start   = 1'b1;
    bus.data_in = 32'hFFFF_FFFF;
    bus.crc_in  = 8'h00;

    // Reset held with start asserted: everything stays cleared.
    repeat (3) begin
      @(negedge clk);
      check_cleared("reset");
    end
    // Release reset with start still high: accepted on the very next edge.
    rst = 1'b1;
    push_exp(crc_model(32'hFFFF_FFFF), crc_model(32'hFFFF_FFFF) == 7'h00, edge_cnt + 1);
    @(negedge clk);
    bus.start = 1'b0;
    check("post_reset_busy", 32'(bus.busy), 32'd1);
    drain();

    // Known vectors from the link definition.
    issue(32'h0000_0001, 8'h09, 1'b1, 7'h09, 1'b1); drain();
    issue(32'h8000_0000, 8'h1B, 1'b1, 7'h1B, 1'b1); drain();
    issue(32'h8000_0001, 8'h12, 1'b1, 7'h12, 1'b1); drain();
    issue(32'h8000_0000, 8'h1A, 1'b1, 7'h1B, 1'b0); drain();
    issue(32'h0000_0000, 8'h80, 1'b1, 7'h00, 1'b1); drain();

    // Starts while busy are dropped; only the first word produces a result.
    issue(32'h0000_0001, 8'h09, 1'b1, 7'h09, 1'b1);
    k = edge_cnt;
    while (edge_cnt < k + 4) @(negedge clk);
    bus.start = 1'b1; bus.data_in = 32'hDEAD_BEEF; bus.crc_in = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_mid_word", 32'(bus.busy), 32'd1);
    while (edge_cnt < k + 19) @(negedge clk);
    bus.start = 1'b1; bus.data_in = 32'h1234_5678; bus.crc_in = 8'h7F;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Start held through done: second word accepted in the done cycle.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 32'hA5A5_0F0F;
    bus.crc_in  = {1'b0, crc_model(32'hA5A5_0F0F)};
    e1 = edge_cnt + 1 + LAT;
    push_exp(crc_model(32'hA5A5_0F0F), 1'b1, edge_cnt + 1);
    while (edge_cnt < e1) @(negedge clk);
    check("b2b_done_seen", 32'(bus.done), 32'd1);
    bus.data_in = 32'h0F0F_A5A5;
    bus.crc_in  = 8'h00;
    push_exp(crc_model(32'h0F0F_A5A5), crc_model(32'h0F0F_A5A5) == 7'h00, edge_cnt + 1);
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Reset mid-word aborts with no done and clears outputs.
    issue(32'hFFFF_0000, 8'h00, 1'b0, 7'h00, 1'b0);
    k = edge_cnt;
    while (edge_cnt < k + 9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cleared("abort");
    rst = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'h0000_0001, 8'h09, 1'b1, 7'h09, 1'b1);
    drain();

    // Randomized words against the division model, some with corrupted CRC.
    for (int n = 0; n < 20; n++) begin
      d = $urandom;
      m = crc_model(d);
      c = {1'($urandom_range(0, 1)), m};
      if ($urandom_range(0, 2) == 0) c[6:0] = m ^ 7'($urandom_range(1, 127));
      issue(d, c, 1'b1, m, c[6:0] == m);
      drain();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/crc_7_check.md
# crc_7_check

Receive-side companion of the CRC-7 generator. It accepts a data word together with the CRC-7 that travelled with it, recomputes the CRC bit-serially, and reports match or mismatch with a one-cycle `done` pulse. It sits at the link receiver, between the deserializer and the packet consumer, and uses the same polynomial (x^7 + x^3 + 1) and MSB-first ordering as the generator.

## Interface
Parameters:
- `DATAWIDTH`, 32: data word width in bits; minimum 8.
- `POLY`, 7'h09: low 7 bits of the generator polynomial; x^7 is implicit.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `start` input 1: request strobe, sampled only in IDLE.
- `data_in` input DATAWIDTH: received data word, latched on the accepting edge.
- `crc_in` input 8: received CRC; bits [6:0] are used and bit 7 is ignored (matches the generator's 8-bit output).
- `busy` output 1: high from the accepting edge until the edge that raises `done`.
- `done` output 1: one-cycle pulse when the result is valid.
- `crc_ok` output 1: 1 when the computed CRC equals `crc_in[6:0]`; held until the next `done`.
- `crc_calc` output 7: computed CRC; held until the next `done`.

## Operation
- CRC definition: remainder of (data · x^7) mod G, with initial remainder 0, MSB first, no reflection and no final XOR.
- Per-bit update, for a 7-bit register `r`:
  - `fb = bit ^ r[6]`
  - `r <= {r[5:0], 1'b0} ^ (fb ? POLY : 0)`
- FSM has three states: IDLE, SHIFT, CHECK.
- IDLE:
  - `busy` is 0.
  - On `start=1`: latch `data_in` into a shift register, latch `crc_in[6:0]`, clear `r` and the bit counter, and go to SHIFT.
- SHIFT:
  - Each cycle, process the MSB of the shift register, shift the register left by 1, and increment the counter.
  - After DATAWIDTH bits, go to CHECK.
- CHECK (one cycle):
  - `crc_calc <= r`
  - `crc_ok <= (r == latched crc)`
  - `done <= 1`
  - Go to IDLE.
- `start` is ignored while `busy=1`. There is no queueing and no error flag for a dropped request.
- The counter is ceil(log2(DATAWIDTH+1)) bits wide, so it never wraps during a word.
- `crc_ok` and `crc_calc` change only on the edge that raises `done`.

## Timing
- Reset (`rst=0` at a rising edge):
  - State goes to IDLE.
  - `busy=0`, `done=0`, `crc_ok=0`, `crc_calc=0`; shift register, `r` and counter are cleared.
  - Reset takes priority over `start`.
  - A reset mid-word aborts the word with no `done`.
- Let edge k be the edge that accepts `start`:
  - SHIFT processes one data bit per edge, k+1 through k+DATAWIDTH.
  - CHECK occupies edge k+DATAWIDTH+1.
  - `done` is high for exactly one cycle after edge k+DATAWIDTH+1. That is a latency of DATAWIDTH+1 edges, 33 for the default.
- `busy` is high after edges k through k+DATAWIDTH, and low in the cycle where `done` is high.
- Back-to-back operation:
  - `start` held high during the `done` cycle is accepted, because the FSM is in IDLE.
  - Sustained throughput is one word per DATAWIDTH+2 cycles.
- `start` is level-sampled. If it is held high, a new word is taken each time the FSM returns to IDLE.

## Structure
- Shared package `crc7_pkg` holds:
  - the `CRC7_POLY` constant (7'h09)
  - `CRC7_WIDTH` (7)
  - the FSM state encoding
  - The generator and the checker both import it.
- Natural sub-module: `crc7_bit_step`, a combinational single-bit LFSR update taking r, bit and POLY and producing next r. It is reused by the generator rewrite and instantiated once here.
- Everything else stays inline: FSM, counter, shift register and output registers. Target size is about 150 lines.

## Test plan
- Reset:
  - Hold `rst=0` for 3 cycles while `start=1` and `data_in=0xFFFFFFFF`. Required: `busy`, `done`, `crc_ok` and `crc_calc` all stay 0.
  - Release `rst`. Required: a word is accepted on the next edge.
- Known vectors, checking `done` exactly 33 edges after acceptance:
  - `data_in=0x00000001`, `crc_in=0x09` → `crc_calc=0x09`, `crc_ok=1`.
  - `data_in=0x80000000`, `crc_in=0x1B` → `crc_calc=0x1B`, `crc_ok=1`.
  - `data_in=0x80000001`, `crc_in=0x12` → `crc_calc=0x12`, `crc_ok=1`.
- Mismatch:
  - `data_in=0x80000000`, `crc_in=0x1A` → `crc_ok=0`, `crc_calc=0x1B`.
  - `data_in=0x00000000`, `crc_in=0x80` → `crc_ok=1`, `crc_calc=0x00` (bit 7 ignored).
- Busy and back-to-back:
  - Pulse `start` at edges k+5 and k+20 with different data. Required: both are ignored, and the result reflects only the word from edge k.
  - Hold `start` high through the `done` cycle. Required: the next word's `done` arrives 34 cycles after the previous `done`.
- Reset mid-operation:
  - Assert `rst=0` at edge k+10. Required: no `done`, `busy=0` on the next cycle, and outputs cleared to 0.
  - Then run `0x00000001`/`0x09`. Required: `crc_ok=1`, with no residue from the aborted word.
